uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares the single UART message path (message FSM, shift register, TX FIFO) between NUM_REQ message requesters.
- Grants one requester at a time and issues a one-cycle send_msg to the message FSM. It waits for end-of-message, then waits for the TX FIFO to drain, then acks the requester and rotates priority.
- Sits between the user/request logic and the message FSM.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, 2, width of sel; must satisfy 2**IDX_W >= NUM_REQ.
- TIMEOUT_CYC, 65535, maximum cycles spent in WAIT_MSG before abort. The timeout counter is $clog2(TIMEOUT_CYC+1) bits wide.

Ports:
- clk, input, 1, system clock; all logic is rising-edge.
- rst_n, input, 1, asynchronous active-low reset.
- req, input, NUM_REQ, level request per requester; held until its ack.
- fifo_empty, input, 1, TX FIFO empty.
- end_of_msg, input, 1, message FSM has consumed the last character.
- grant, output, NUM_REQ, one-hot owner of the message path; all zeros when none.
- sel, output, IDX_W, binary index of the granted requester; muxes message data into the shift register.
- send_msg, output, 1, one-cycle start strobe to the message FSM.
- ack, output, NUM_REQ, one-cycle completion pulse to the owner.
- busy, output, 1, high whenever state is not IDLE.
- timeout_err, output, 1, one-cycle pulse on WAIT_MSG timeout.

Behaviour:
- Reset (async, rst_n=0) sets:
  - state = IDLE.
  - grant = 0, sel = 0, ack = 0, send_msg = 0, busy = 0, timeout_err = 0.
  - Priority pointer last = NUM_REQ-1, so requester 0 has first priority.
  - Timeout counter = 0.
- Reset mid-operation aborts immediately. No ack is issued; the message FSM is reset by the same rst_n.
- All outputs are registered or decoded from registered state only, with no combinational path from any input to any output.
- States: IDLE, START, WAIT_MSG, DRAIN, DONE.
- IDLE:
  - Condition to leave: (|req) && fifo_empty.
  - Winner: the first set bit of req, searching upward from index last+1 modulo NUM_REQ.
  - On that edge, register grant (one-hot) and sel (index), then go to START.
  - If fifo_empty=0, stay in IDLE even with requests pending.
- START:
  - send_msg=1 for exactly this one cycle.
  - Next state: WAIT_MSG. Clear the timeout counter.
- WAIT_MSG:
  - If end_of_msg=1, go to DRAIN.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYC, pulse timeout_err for 1 cycle and go to DRAIN.
- DRAIN:
  - When fifo_empty=1, go to DONE; otherwise hold.
  - There is no timeout in DRAIN; the UART always drains.
- DONE:
  - ack[sel]=1 for this one cycle.
  - last <= sel. Next state: IDLE.
  - grant clears to 0 on the DONE→IDLE edge.
- Ack on timeout: ack is still issued after a timeout. Requesters distinguish an aborted message by timeout_err.
- Timing: grant and sel are stable from START through DONE inclusive. Latency from a qualifying req in IDLE:
  - cycle+1: grant valid and send_msg high.
  - cycle+2: WAIT_MSG.
- Minimum transaction length is 4 cycles after grant (START, WAIT_MSG, DRAIN, DONE). Back-to-back grants are separated by at least one IDLE cycle.
- Request changes during a transaction:
  - A req deassert by the owner mid-transaction is ignored; the transaction completes and is acked.
  - A new req arriving during a transaction is not sampled until IDLE.
- Simultaneous events:
  - end_of_msg and timeout on the same cycle: end_of_msg wins, with no timeout_err.
  - end_of_msg already high on entry to WAIT_MSG: DRAIN on the next edge.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,2,3,0,... and no requester waits more than NUM_REQ-1 transactions.
- Single requester: the same requester is granted repeatedly.

Test Plan:
- Reset then req=4'b0001, fifo_empty=1 -> next cycle grant=0001, sel=0, send_msg=1 for 1 cycle, busy=1. Assert end_of_msg 10 cycles later -> ack=0001 two cycles after end_of_msg (fifo_empty=1), then grant=0.
- req=4'b1111 held, 8 transactions -> grant order 0001,0010,0100,1000,0001,0010,0100,1000; exactly one ack per transaction.
- req=4'b0101 with last=0 -> grant=0100; next transaction grant=0001; req changes mid-transaction do not alter grant.
- TIMEOUT_CYC=20, end_of_msg never asserted -> timeout_err pulse 20 cycles after entering WAIT_MSG, then DRAIN, then ack.
- fifo_empty=0 while req=0010 -> stays IDLE, send_msg=0. Release fifo_empty -> grant next cycle. Hold fifo_empty=0 in DRAIN for 50 cycles -> no ack until it rises.
- rst_n=0 during WAIT_MSG -> all outputs 0 immediately (async). Reset release with req=1000 -> grant=1000, since last=NUM_REQ-1 gives priority starting at 0 and only 3 requests.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the message requesters, the message FSM / TX FIFO
// status, and the round-robin UART TX arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) ();
  logic [NUM_REQ-1:0] req;
  logic               fifo_empty;
  logic               end_of_msg;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   sel;
  logic               send_msg;
  logic [NUM_REQ-1:0] ack;
  logic               busy;
  logic               timeout_err;

  modport master (
    output req, fifo_empty, end_of_msg,
    input  grant, sel, send_msg, ack, busy, timeout_err
  );

  modport slave (
    input  req, fifo_empty, end_of_msg,
    output grant, sel, send_msg, ack, busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART message path between NUM_REQ requesters:
// grant, start strobe, wait for end of message, drain the FIFO, ack, rotate.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int IDX_W       = 2,
  parameter int TIMEOUT_CYC = 65535
) (
  input logic             clk,
  input logic             rst_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_MSG,
    DRAIN,
    DONE
  } state_t;

  state_t             state, state_next;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tmo_q, tmo_d;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;

  // Search upward from the requester after the last owner, wrapping at NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last_q) + i) % NUM_REQ);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_next = state;
    grant_d    = grant_q;
    sel_d      = sel_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    tmo_d      = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_found && bus.fifo_empty) begin
          grant_d    = NUM_REQ'(1) << win_idx;
          sel_d      = win_idx;
          state_next = START;
        end
      end
      START: begin
        cnt_d      = '0;
        state_next = WAIT_MSG;
      end
      WAIT_MSG: begin
        // end_of_msg takes precedence over a timeout landing on the same edge
        if (bus.end_of_msg) begin
          state_next = DRAIN;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          cnt_d      = cnt_q + CNT_W'(1);
          tmo_d      = 1'b1;
          state_next = DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (bus.fifo_empty) begin
          state_next = DONE;
        end
      end
      DONE: begin
        last_d     = sel_q;
        grant_d    = '0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state   <= state_next;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // Every output comes from registered state only.
  assign bus.grant       = grant_q;
  assign bus.sel         = sel_q;
  assign bus.send_msg    = (state == START);
  assign bus.ack         = (state == DONE) ? grant_q : '0;
  assign bus.busy        = (state != IDLE);
  assign bus.timeout_err = tmo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a cycle vector table, directed
// transactions for timeout/drain/reset corners, and randomized transactions.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;
  localparam int TIMEOUT = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  int         checks   = 0;
  int         failures = 0;
  logic [1:0] model_last;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IDX_W(IDX_W),
    .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [3:0] req;
    logic       fe;
    logic       eom;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       send;
    logic [3:0] ack;
    logic       busy;
  } vec_t;

  vec_t vecs[23];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Drive inputs at the falling edge, cross one rising edge, return at the next falling edge.
  task automatic applyStimulus(input logic [3:0] r, input logic fe, input logic eom);
    bus.req        = r;
    bus.fifo_empty = fe;
    bus.end_of_msg = eom;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkAll(input string tag, input logic [3:0] grant, input logic [1:0] sel,
                          input logic send, input logic [3:0] ack, input logic busy,
                          input logic tmo, input bit use_sel);
    checkOutput({tag, ".grant"}, 32'(bus.grant), 32'(grant));
    if (use_sel) checkOutput({tag, ".sel"}, 32'(bus.sel), 32'(sel));
    checkOutput({tag, ".send_msg"}, 32'(bus.send_msg), 32'(send));
    checkOutput({tag, ".ack"}, 32'(bus.ack), 32'(ack));
    checkOutput({tag, ".busy"}, 32'(bus.busy), 32'(busy));
    checkOutput({tag, ".timeout_err"}, 32'(bus.timeout_err), 32'(tmo));
  endtask

  function automatic logic [1:0] rrPick(input logic [3:0] r, input logic [1:0] last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx = (int'(last) + k) % NUM_REQ;
      if (r[idx]) return idx[1:0];
    end
    return last;
  endfunction

  // One complete transaction predicted from phase lengths: START, WAIT_MSG until
  // end_of_msg or TIMEOUT cycles, DRAIN until fifo_empty, one DONE cycle, then IDLE.
  task automatic runTxn(input string tag, input logic [3:0] r, input int eom_dly,
                        input int drain_dly);
    logic [1:0] exp_idx;
    logic [3:0] exp_grant;
    bit         timed;
    int         wait_len;
    int         done_n;
    exp_idx   = rrPick(r, model_last);
    exp_grant = 4'(1) << exp_idx;
    timed     = (eom_dly >= TIMEOUT);
    wait_len  = timed ? TIMEOUT : eom_dly + 1;
    done_n    = wait_len + drain_dly + 1;
    applyStimulus(r, 1'b1, 1'b0);
    checkAll({tag, ".start"}, exp_grant, exp_idx, 1'b1, 4'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(4'($urandom), 1'b1, 1'b0);
    for (int n = 0; n <= done_n + 1; n++) begin
      if (n <= done_n)
        checkAll($sformatf("%s.c%0d", tag, n), exp_grant, exp_idx, 1'b0,
                 (n == done_n) ? exp_grant : 4'b0, 1'b1, timed && (n == wait_len), 1'b1);
      else
        checkAll({tag, ".idle"}, 4'b0, 2'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0);
      if (n <= done_n)
        applyStimulus(4'($urandom),
                      !((n >= wait_len) && (n < wait_len + drain_dly)),
                      n == eom_dly);
    end
    model_last     = exp_idx;
    bus.req        = 4'b0;
    bus.end_of_msg = 1'b0;
    bus.fifo_empty = 1'b1;
  endtask

  initial begin
    //            req     fe    eom    grant    sel   send  ack      busy
    vecs[0]  = '{4'b0001, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1, 4'b0000, 1'b1};
    vecs[1]  = '{4'b0001, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b0, 4'b0000, 1'b1};
    vecs[2]  = '{4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, 4'b0000, 1'b1};
    vecs[3]  = '{4'b0001, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b0, 4'b0000, 1'b1};
    vecs[4]  = '{4'b0001, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b0, 4'b0001, 1'b1};
    vecs[5]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0};
    vecs[6]  = '{4'b0101, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b1, 4'b0000, 1'b1};
    vecs[7]  = '{4'b0001, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0, 4'b0000, 1'b1};
    vecs[8]  = '{4'b0001, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b0, 4'b0000, 1'b1};
    vecs[9]  = '{4'b0000, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0, 4'b0100, 1'b1};
    vecs[10] = '{4'b0101, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0};
    vecs[11] = '{4'b0101, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1, 4'b0000, 1'b1};
    vecs[12] = '{4'b0000, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b0, 4'b0000, 1'b1};
    vecs[13] = '{4'b0000, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, 4'b0000, 1'b1};
    vecs[14] = '{4'b0000, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b0, 4'b0001, 1'b1};
    vecs[15] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0};
    vecs[16] = '{4'b0010, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0};
    vecs[17] = '{4'b0010, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0};
    vecs[18] = '{4'b0010, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b1, 4'b0000, 1'b1};
    vecs[19] = '{4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b0, 4'b0000, 1'b1};
    vecs[20] = '{4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b0, 4'b0000, 1'b1};
    vecs[21] = '{4'b0010, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b0, 4'b0010, 1'b1};
    vecs[22] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0};

    rst_n          = 1'b0;
    bus.req        = 4'b0;
    bus.fifo_empty = 1'b1;
    bus.end_of_msg = 1'b0;
    repeat (2) @(negedge clk);
    checkAll("reset", 4'b0, 2'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    checkAll("post_reset_idle", 4'b0, 2'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i].req, vecs[i].fe, vecs[i].eom);
      checkAll($sformatf("vec%0d", i), vecs[i].grant, vecs[i].sel, vecs[i].send,
               vecs[i].ack, vecs[i].busy, 1'b0, vecs[i].busy);
    end
    model_last = 2'd1;

    for (int k = 0; k < 8; k++)
      runTxn($sformatf("fair%0d", k), 4'b1111, int'($urandom_range(0, 3)), 0);

    runTxn("timeout", 4'b0001, TIMEOUT, 0);
    runTxn("eom_vs_timeout", 4'b0100, TIMEOUT - 1, 1);
    runTxn("eom_late", 4'b1000, TIMEOUT + 5, 2);
    runTxn("long_drain", 4'b0010, 3, 50);
    runTxn("single_a", 4'b0010, 0, 0);
    runTxn("single_b", 4'b0010, 1, 0);

    for (int k = 0; k < 40; k++)
      runTxn($sformatf("rand%0d", k), 4'($urandom_range(1, 15)),
             int'($urandom_range(0, TIMEOUT + 3)), int'($urandom_range(0, 5)));

    runTxn("pre_reset", 4'b0001, 1, 0);
    applyStimulus(4'b0001, 1'b1, 1'b0);
    applyStimulus(4'b0001, 1'b1, 1'b0);
    applyStimulus(4'b0001, 1'b1, 1'b0);
    checkAll("in_wait", 4'b0001, 2'd0, 1'b0, 4'b0, 1'b1, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    checkAll("async_reset", 4'b0, 2'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkAll("reset_hold", 4'b0, 2'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1);
    rst_n      = 1'b1;
    model_last = 2'd3;
    runTxn("after_reset", 4'b1001, 2, 0);
    runTxn("only_top", 4'b1000, 2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
